// File: rtl/jaa_pkg.sv
// Shared definitions for the Java-bytecode-to-ARM translator: JVM opcode constants
// and the bytecode fetch state encoding.
package jaa_pkg;

  localparam logic [7:0] OP_ICONST_0 = 8'h03;
  localparam logic [7:0] OP_ICONST_1 = 8'h04;
  localparam logic [7:0] OP_ICONST_2 = 8'h05;
  localparam logic [7:0] OP_ICONST_3 = 8'h06;
  localparam logic [7:0] OP_ICONST_4 = 8'h07;
  localparam logic [7:0] OP_ICONST_5 = 8'h08;
  localparam logic [7:0] OP_BIPUSH   = 8'h10;
  localparam logic [7:0] OP_SIPUSH   = 8'h11;
  localparam logic [7:0] OP_ILOAD    = 8'h15;
  localparam logic [7:0] OP_ILOAD_0  = 8'h1A;
  localparam logic [7:0] OP_ILOAD_1  = 8'h1B;
  localparam logic [7:0] OP_ILOAD_2  = 8'h1C;
  localparam logic [7:0] OP_ILOAD_3  = 8'h1D;
  localparam logic [7:0] OP_ISTORE   = 8'h36;
  localparam logic [7:0] OP_ISTORE_0 = 8'h3B;
  localparam logic [7:0] OP_ISTORE_1 = 8'h3C;
  localparam logic [7:0] OP_ISTORE_2 = 8'h3D;
  localparam logic [7:0] OP_ISTORE_3 = 8'h3E;
  localparam logic [7:0] OP_DUP      = 8'h59;
  localparam logic [7:0] OP_DUP_X1   = 8'h5A;
  localparam logic [7:0] OP_DUP_X2   = 8'h5B;
  localparam logic [7:0] OP_DUP2     = 8'h5C;
  localparam logic [7:0] OP_DUP2_X1  = 8'h5D;
  localparam logic [7:0] OP_DUP2_X2  = 8'h5E;
  localparam logic [7:0] OP_SWAP     = 8'h5F;
  localparam logic [7:0] OP_IADD     = 8'h60;
  localparam logic [7:0] OP_IINC     = 8'h84;
  localparam logic [7:0] OP_RETURN   = 8'hB1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_OP,
    ST_CAP_OP,
    ST_CAP_OPND1,
    ST_CAP_OPND2,
    ST_PRESENT,
    ST_HALT
  } fetch_state_t;

endpackage

// File: rtl/bytecode_length_decode.sv
// Combinational opcode classifier: number of inline operand bytes and whether the
// opcode is outside the supported subset.
module bytecode_length_decode
  import jaa_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] length,
  output logic       unknown
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    length  = 2'd0;
    unknown = 1'b0;
    case (opcode) inside
      [OP_ICONST_0:OP_ICONST_5],
      [OP_ILOAD_0:OP_ILOAD_3],
      [OP_ISTORE_0:OP_ISTORE_3],
      [OP_DUP:OP_SWAP],
      OP_IADD,
      OP_RETURN:                     length = 2'd0;
      OP_BIPUSH, OP_ILOAD, OP_ISTORE: length = 2'd1;
      OP_SIPUSH, OP_IINC:            length = 2'd2;
      default:                       unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/bytecode_fetch.sv
// Bytecode fetch stage: walks a synchronous byte-wide memory and hands one complete
// JVM instruction (opcode plus inline operands) at a time to the translator.
module bytecode_fetch
  import jaa_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_pc,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  ins_valid,
  input  logic                  ins_ready,
  output logic [7:0]            ins_opcode,
  output logic [7:0]            ins_operand1,
  output logic [7:0]            ins_operand2,
  output logic [1:0]            ins_length,
  output logic [ADDR_WIDTH-1:0] ins_pc,
  output logic                  ins_unknown,
  output logic                  busy,
  output logic                  halted
);

  fetch_state_t          state;
  fetch_state_t          state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [1:0]            dec_length;
  logic                  dec_unknown;
  logic                  start_ok;

  // Decodes the byte arriving this cycle; only meaningful in CAP_OP.
  bytecode_length_decode u_length_decode (
    .opcode  (mem_rdata),
    .length  (dec_length),
    .unknown (dec_unknown)
  );

  assign start_ok  = start && (state == ST_IDLE || state == ST_HALT);
  assign mem_addr  = pc;
  assign ins_valid = (state == ST_PRESENT);
  assign busy      = (state != ST_IDLE) && (state != ST_HALT);
  assign halted    = (state == ST_HALT);

  always_comb begin
    state_next = state;
    mem_rd_en  = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) state_next = ST_FETCH_OP;
      end
      ST_FETCH_OP: begin
        mem_rd_en  = 1'b1;
        state_next = ST_CAP_OP;
      end
      ST_CAP_OP: begin
        if (dec_length == 2'd0) begin
          state_next = ST_PRESENT;
        end else begin
          mem_rd_en  = 1'b1;
          state_next = ST_CAP_OPND1;
        end
      end
      ST_CAP_OPND1: begin
        if (ins_length == 2'd2) begin
          mem_rd_en  = 1'b1;
          state_next = ST_CAP_OPND2;
        end else begin
          state_next = ST_PRESENT;
        end
      end
      ST_CAP_OPND2: state_next = ST_PRESENT;
      ST_PRESENT: begin
        if (ins_ready) state_next = (ins_opcode == OP_RETURN) ? ST_HALT : ST_FETCH_OP;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= '0;
      ins_pc       <= '0;
      ins_opcode   <= '0;
      ins_operand1 <= '0;
      ins_operand2 <= '0;
      ins_length   <= '0;
      ins_unknown  <= 1'b0;
    end else begin
      // Every issued read advances pc; wrap at the top of memory is intentional.
      if (start_ok)       pc <= start_pc;
      else if (mem_rd_en) pc <= pc + ADDR_WIDTH'(1);

      case (state)
        ST_FETCH_OP: ins_pc <= pc;
        ST_CAP_OP: begin
          ins_opcode  <= mem_rdata;
          ins_length  <= dec_length;
          ins_unknown <= dec_unknown;
          if (dec_length == 2'd0) begin
            ins_operand1 <= '0;
            ins_operand2 <= '0;
          end
        end
        ST_CAP_OPND1: begin
          ins_operand1 <= mem_rdata;
          if (ins_length != 2'd2) ins_operand2 <= '0;
        end
        ST_CAP_OPND2: ins_operand2 <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bytecode_fetch.sv
// Self-checking bench for bytecode_fetch: vector table, directed corner sequences and
// randomized programs compared against a memory-walking reference model.
module tb_bytecode_fetch;

  localparam int AW       = 10;
  localparam int MEM_SIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic          ins_ready = 1'b0;
  logic [7:0]    mem_rdata = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic          ins_valid;
  logic [7:0]    ins_opcode, ins_operand1, ins_operand2;
  logic [1:0]    ins_length;
  logic [AW-1:0] ins_pc;
  logic          ins_unknown, busy, halted;

  bytecode_fetch #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_pc     (start_pc),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .ins_opcode   (ins_opcode),
    .ins_operand1 (ins_operand1),
    .ins_operand2 (ins_operand2),
    .ins_length   (ins_length),
    .ins_pc       (ins_pc),
    .ins_unknown  (ins_unknown),
    .busy         (busy),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [MEM_SIZE];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct packed {
    logic [7:0]    op;
    logic [7:0]    o1;
    logic [7:0]    o2;
    logic [1:0]    len;
    logic          unk;
    logic [AW-1:0] pc;
  } bundle_t;

  bundle_t cur;
  assign cur = {ins_opcode, ins_operand1, ins_operand2, ins_length, ins_unknown, ins_pc};

  bundle_t got_q[$];
  int      acc_cyc_q[$];
  bundle_t exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: accepted bundles, stability under backpressure, no reads while presenting.
  bundle_t held;
  logic    hold_pending = 1'b0;
  int      hold_viol = 0;
  int      rd_viol = 0;
  always @(negedge clk) begin
    if (hold_pending && !(ins_valid && cur == held)) hold_viol++;
    if (ins_valid && mem_rd_en) rd_viol++;
    if (!reset && ins_valid && ins_ready) begin
      got_q.push_back(cur);
      acc_cyc_q.push_back(cycle);
    end
    hold_pending = !reset && ins_valid && !ins_ready;
    held = cur;
  end

  // Reference model: operand counts straight from the JVM opcode list.
  function automatic void ref_decode(input logic [7:0] op, output int len, output logic unk);
    unk = 1'b0;
    if (op inside {[8'h03:8'h08], [8'h1A:8'h1D], [8'h3B:8'h3E], [8'h59:8'h60], 8'hB1}) len = 0;
    else if (op inside {8'h10, 8'h15, 8'h36}) len = 1;
    else if (op inside {8'h11, 8'h84}) len = 2;
    else begin
      len = 0;
      unk = 1'b1;
    end
  endfunction

  task automatic build_expected(input int sp);
    int addr;
    int len;
    logic unk;
    bundle_t b;
    exp_q.delete();
    addr = sp;
    for (int n = 0; n < 64; n++) begin
      ref_decode(mem[addr], len, unk);
      b.op  = mem[addr];
      b.o1  = (len >= 1) ? mem[(addr + 1) % MEM_SIZE] : 8'h00;
      b.o2  = (len == 2) ? mem[(addr + 2) % MEM_SIZE] : 8'h00;
      b.len = 2'(len);
      b.unk = unk;
      b.pc  = AW'(addr);
      exp_q.push_back(b);
      addr = (addr + 1 + len) % MEM_SIZE;
      if (b.op == 8'hB1) break;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    ins_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    got_q.delete();
    acc_cyc_q.delete();
  endtask

  task automatic fill_mem();
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'hB1;
  endtask

  task automatic poke(input int a, input logic [7:0] d);
    mem[a % MEM_SIZE] = d;
  endtask

  task automatic launch(input int pc);
    start_pc = AW'(pc);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edge count includes the edge that sampled start.
  task automatic wait_valid(input int max, output int edges);
    edges = 1;
    while (!ins_valid && edges < max) begin
      tick();
      edges++;
    end
  endtask

  task automatic accept();
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
  endtask

  task automatic wait_halted(input int max, input bit rnd, output bit ok);
    int n;
    n = 0;
    while (!halted && n < max) begin
      if (rnd) ins_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    ok = halted;
  endtask

  task automatic expect_bundle(input string name, input int idx, input bundle_t exp);
    if (idx < got_q.size()) check(name, got_q[idx], exp);
    else check({name, "_missing"}, 0, 1);
  endtask

  task automatic compare_queue(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check(name, got_q[i], exp_q[i]);
  endtask

  // With ready held high, acceptances are 3 + operand count cycles apart.
  task automatic gap_check(input string name);
    for (int i = 1; i < acc_cyc_q.size(); i++)
      check(name, acc_cyc_q[i] - acc_cyc_q[i-1], 3 + got_q[i].len);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         sp;
    logic [7:0] e_o1, e_o2;
    logic [1:0] e_len;
    logic       e_unk;
    int         e_lat;
  } vec_t;

  vec_t vecs[16];
  logic [7:0] pool [15] = '{8'h03, 8'h05, 8'h08, 8'h1A, 8'h1D, 8'h3B, 8'h3E, 8'h59,
                            8'h5F, 8'h60, 8'h10, 8'h15, 8'h36, 8'h11, 8'h84};

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t    v;
    int      edges;
    int      reads;
    int      sp;
    bit      ok;
    bit      hi;
    bundle_t snap;
    logic [7:0] b;

    vecs = '{
      '{8'h03, 8'hAA, 8'hBB, 'h000, 8'h00, 8'h00, 2'd0, 1'b0, 3},
      '{8'h08, 8'h11, 8'h22, 'h005, 8'h00, 8'h00, 2'd0, 1'b0, 3},
      '{8'h1A, 8'h00, 8'h00, 'h100, 8'h00, 8'h00, 2'd0, 1'b0, 3},
      '{8'h3E, 8'h00, 8'h00, 'h3FF, 8'h00, 8'h00, 2'd0, 1'b0, 3},
      '{8'h5F, 8'h00, 8'h00, 'h044, 8'h00, 8'h00, 2'd0, 1'b0, 3},
      '{8'h60, 8'h00, 8'h00, 'h045, 8'h00, 8'h00, 2'd0, 1'b0, 3},
      '{8'h10, 8'h7F, 8'h55, 'h010, 8'h7F, 8'h00, 2'd1, 1'b0, 4},
      '{8'h15, 8'h03, 8'h99, 'h3FE, 8'h03, 8'h00, 2'd1, 1'b0, 4},
      '{8'h36, 8'h05, 8'h00, 'h3FF, 8'h05, 8'h00, 2'd1, 1'b0, 4},
      '{8'h11, 8'h12, 8'h34, 'h020, 8'h12, 8'h34, 2'd2, 1'b0, 5},
      '{8'h84, 8'h01, 8'hFF, 'h3FE, 8'h01, 8'hFF, 2'd2, 1'b0, 5},
      '{8'hFE, 8'h00, 8'h00, 'h030, 8'h00, 8'h00, 2'd0, 1'b1, 3},
      '{8'h02, 8'h00, 8'h00, 'h031, 8'h00, 8'h00, 2'd0, 1'b1, 3},
      '{8'h09, 8'h00, 8'h00, 'h032, 8'h00, 8'h00, 2'd0, 1'b1, 3},
      '{8'h61, 8'h00, 8'h00, 'h033, 8'h00, 8'h00, 2'd0, 1'b1, 3},
      '{8'h00, 8'h00, 8'h00, 'h200, 8'h00, 8'h00, 2'd0, 1'b1, 3}
    };

    fill_mem();
    do_reset();
    check("reset_state", {mem_rd_en, mem_addr, ins_valid, cur, busy, halted}, 0);

    // Single instruction followed by return, one table row at a time.
    for (int i = 0; i < 16; i++) begin
      v = vecs[i];
      do_reset();
      fill_mem();
      poke(v.sp, v.b0);
      if (v.e_len >= 1) poke(v.sp + 1, v.b1);
      if (v.e_len == 2) poke(v.sp + 2, v.b2);
      launch(v.sp);
      wait_valid(12, edges);
      check("vec_latency", edges, v.e_lat);
      check("vec_bundle", cur, {v.b0, v.e_o1, v.e_o2, v.e_len, v.e_unk, AW'(v.sp)});
      check("vec_busy", busy, 1);
      accept();
      wait_valid(12, edges);
      check("vec_next_pc", ins_pc, (v.sp + 1 + v.e_len) % MEM_SIZE);
      check("vec_next_op", ins_opcode, 8'hB1);
      accept();
      tick();
      check("vec_halted", {halted, busy, ins_valid}, 3'b100);
    end

    // 03 3B B1 with ready held high, then restart from HALT.
    do_reset();
    fill_mem();
    poke(0, 8'h03); poke(1, 8'h3B); poke(2, 8'hB1);
    ins_ready = 1'b1;
    launch(0);
    wait_halted(40, 1'b0, ok);
    check("seq1_halted", ok, 1);
    check("seq1_count", got_q.size(), 3);
    expect_bundle("seq1_b0", 0, {8'h03, 8'h00, 8'h00, 2'd0, 1'b0, 10'h000});
    expect_bundle("seq1_b1", 1, {8'h3B, 8'h00, 8'h00, 2'd0, 1'b0, 10'h001});
    expect_bundle("seq1_b2", 2, {8'hB1, 8'h00, 8'h00, 2'd0, 1'b0, 10'h002});
    gap_check("seq1_gap");
    reads = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      reads += int'(mem_rd_en);
    end
    check("seq1_halt_no_read", reads, 0);
    check("seq1_still_halted", halted, 1);
    got_q.delete();
    acc_cyc_q.delete();
    launch(1);
    wait_halted(40, 1'b0, ok);
    check("restart_count", got_q.size(), 2);
    expect_bundle("restart_b0", 0, {8'h3B, 8'h00, 8'h00, 2'd0, 1'b0, 10'h001});

    // 10 7F 11 12 34 B1: mixed lengths and start latency.
    do_reset();
    fill_mem();
    poke(0, 8'h10); poke(1, 8'h7F); poke(2, 8'h11); poke(3, 8'h12); poke(4, 8'h34); poke(5, 8'hB1);
    ins_ready = 1'b1;
    launch(0);
    wait_valid(12, edges);
    check("seq2_latency", edges, 4);
    wait_halted(40, 1'b0, ok);
    check("seq2_count", got_q.size(), 3);
    expect_bundle("seq2_b0", 0, {8'h10, 8'h7F, 8'h00, 2'd1, 1'b0, 10'h000});
    expect_bundle("seq2_b1", 1, {8'h11, 8'h12, 8'h34, 2'd2, 1'b0, 10'h002});
    expect_bundle("seq2_b2", 2, {8'hB1, 8'h00, 8'h00, 2'd0, 1'b0, 10'h005});
    gap_check("seq2_gap");

    // Backpressure on istore 05.
    do_reset();
    fill_mem();
    poke(0, 8'h36); poke(1, 8'h05);
    launch(0);
    wait_valid(12, edges);
    snap = cur;
    check("bp_bundle", snap, {8'h36, 8'h05, 8'h00, 2'd1, 1'b0, 10'h000});
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", {mem_rd_en, ins_valid, cur}, {1'b0, 1'b1, snap});
    end
    ins_ready = 1'b1;
    tick();
    check("bp_accepted", got_q.size(), 1);
    check("bp_valid_drop", ins_valid, 0);
    wait_halted(40, 1'b0, ok);

    // iinc whose operands straddle the top of memory.
    do_reset();
    fill_mem();
    poke('h3FF, 8'h84); poke(0, 8'h01); poke(1, 8'h02); poke(2, 8'hB1);
    ins_ready = 1'b1;
    launch('h3FF);
    wait_halted(40, 1'b0, ok);
    check("wrap_count", got_q.size(), 2);
    expect_bundle("wrap_b0", 0, {8'h84, 8'h01, 8'h02, 2'd2, 1'b0, 10'h3FF});
    expect_bundle("wrap_b1", 1, {8'hB1, 8'h00, 8'h00, 2'd0, 1'b0, 10'h002});

    // Reset while fetching the first operand of a sipush.
    do_reset();
    fill_mem();
    poke('h10, 8'h11); poke('h11, 8'h12); poke('h12, 8'h34);
    ins_ready = 1'b1;
    launch('h10);
    tick();
    tick();
    check("mid_busy", {busy, ins_valid}, 2'b10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset_outputs", {mem_rd_en, mem_addr, ins_valid, cur, busy, halted}, 0);
    for (int i = 0; i < 4; i++) tick();
    check("mid_no_bundle", got_q.size(), 0);
    reset = 1'b1;
    start = 1'b1;
    start_pc = 10'h005;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("reset_beats_start", busy, 0);
    tick();
    check("reset_beats_start_idle", {busy, halted}, 2'b00);
    poke('h20, 8'h15); poke('h21, 8'h07);
    launch('h20);
    wait_halted(40, 1'b0, ok);
    check("post_reset_count", got_q.size(), 2);
    expect_bundle("post_reset_b0", 0, {8'h15, 8'h07, 8'h00, 2'd1, 1'b0, 10'h020});
    expect_bundle("post_reset_b1", 1, {8'hB1, 8'h00, 8'h00, 2'd0, 1'b0, 10'h022});

    // Randomized programs against the reference model.
    for (int r = 0; r < 30; r++) begin
      sp = $urandom_range(0, MEM_SIZE - 1);
      hi = (r % 2 == 0);
      do_reset();
      fill_mem();
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 9) < 7) b = pool[$urandom_range(0, 14)];
        else b = 8'($urandom_range(0, 255));
        if (b == 8'hB1) b = 8'h00;
        poke(sp + k, b);
      end
      build_expected(sp);
      ins_ready = hi;
      launch(sp);
      wait_halted(800, !hi, ok);
      check("rand_halted", ok, 1);
      compare_queue("rand_bundle");
      if (hi) gap_check("rand_gap");
    end

    check("hold_stable", hold_viol, 0);
    check("no_read_while_valid", rd_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bytecode_fetch.md
# bytecode_fetch

Upstream stage of the Java-bytecode-to-ARM translator. Reads bytes from a synchronous byte-wide bytecode memory, groups each opcode with its inline operand bytes, and presents one complete JVM instruction at a time to the translator over a valid/ready handshake. The translator then never tracks operand counts or memory cursors itself. Fetching stops after a `return` opcode until restarted.

## Interface
- `ADDR_WIDTH`, default 10: bytecode memory address width (1024 bytes).
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin fetching at `start_pc`. Honoured only in IDLE or HALT.
- `start_pc` in ADDR_WIDTH: first bytecode address.
- `mem_rd_en` out 1: read strobe to bytecode memory.
- `mem_addr` out ADDR_WIDTH: read address.
- `mem_rdata` in 8: read data, valid exactly one cycle after the `mem_rd_en` cycle.
- `ins_valid` out 1: instruction bundle valid.
- `ins_ready` in 1: translator accepts the bundle.
- `ins_opcode` out 8: opcode byte.
- `ins_operand1` out 8: first operand byte; 0 if none.
- `ins_operand2` out 8: second operand byte; 0 if none.
- `ins_length` out 2: operand byte count (0–2).
- `ins_pc` out ADDR_WIDTH: address of the opcode byte.
- `ins_unknown` out 1: opcode not in the length table.
- `busy` out 1: high in any state except IDLE and HALT.
- `halted` out 1: high in HALT.

## Operation
- States: IDLE, FETCH_OP, CAP_OP, CAP_OPND1, CAP_OPND2, PRESENT, HALT.
- IDLE/HALT with `start`: `pc <= start_pc` and go to FETCH_OP. Without `start`, stay.
- FETCH_OP: `mem_rd_en=1`, `mem_addr=pc`, `pc <= pc+1`, `ins_pc <= pc`, then go to CAP_OP.
- CAP_OP: `opcode <= mem_rdata`. Decode the length from `mem_rdata`.
  - Length 0: clear both operands, go to PRESENT.
  - Length ≥1: issue a read of `pc` in this same cycle, `pc <= pc+1`, go to CAP_OPND1.
- CAP_OPND1: `operand1 <= mem_rdata`.
  - Length 2: issue a read of `pc`, `pc++`, go to CAP_OPND2.
  - Otherwise: `operand2 <= 0`, go to PRESENT.
- CAP_OPND2: `operand2 <= mem_rdata`, go to PRESENT.
- PRESENT: `ins_valid=1`.
  - On `ins_ready`: if opcode is 0xB1 (`return`), go to HALT; otherwise go to FETCH_OP.
  - Without `ins_ready`: hold.
- Length table:
  - Length 0: 0x03–0x08 (iconst_0..5), 0x1A–0x1D (iload_n), 0x3B–0x3E (istore_n), 0x59–0x5F (dup family, swap), 0x60 (iadd), 0xB1 (return).
  - Length 1: 0x10 (bipush), 0x15 (iload), 0x36 (istore).
  - Length 2: 0x11 (sipush), 0x84 (iinc).
  - Any other opcode: length 0, `ins_unknown=1`. It is presented normally and fetching continues.
- `pc` is ADDR_WIDTH bits. Wrap-around from 2^ADDR_WIDTH−1 to 0 is silent, including in the middle of an instruction's operands.
- `mem_rd_en=0` in all states not listed above as issuing a read.

## Timing
- Reset values: state IDLE, `pc=0`, `mem_rd_en=0`, `mem_addr=0`, `ins_valid=0`, `ins_opcode/operand1/operand2=0`, `ins_length=0`, `ins_pc=0`, `ins_unknown=0`, `busy=0`, `halted=0`.
- Reset in any state, including mid-operand fetch or PRESENT, aborts immediately. No bundle is emitted.
- Latency from the edge that samples `start` to `ins_valid` high: 3 cycles for length 0, 4 for length 1, 5 for length 2.
- Back-to-back throughput with `ins_ready` held high: one instruction per 3 + length cycles.
- All `ins_*` outputs are registered and stable while `ins_valid && !ins_ready`. `ins_valid` never drops without acceptance, except on reset.
- `start` while `busy` is ignored.
- `reset` and `start` asserted in the same cycle: reset wins.

## Structure
- Shared package `jaa_pkg`:
  - JVM opcode constants (ICONST_0…RETURN, BIPUSH, SIPUSH, IINC, ILOAD, ISTORE).
  - Fetch state enum.
  - The translator reuses the same opcode constants.
- Sub-module `bytecode_length_decode`: purely combinational, opcode → {length[1:0], unknown}. The translator can reuse it later.

## Test plan
- Bytes 03 3B B1 at 0, start_pc=0, ready=1 → bundles (03,len0,pc0), (3B,len0,pc1), (B1,len0,pc2); then `halted=1`, `mem_rd_en` stays 0.
- Bytes 10 7F 11 12 34 B1 → (10,op1=7F,len1,pc0), (11,op1=12,op2=34,len2,pc2), (B1,pc5). First `ins_valid` occurs 4 cycles after `start`.
- Backpressure: `ins_ready=0` for 5 cycles on (36,05) → outputs unchanged, no memory reads issued, accepted on the first ready cycle.
- Wrap: start_pc=0x3FF, mem[3FF]=84, mem[000]=01, mem[001]=02 → (84,op1=01,op2=02,len2,pc=3FF), next opcode fetched from 0x002.
- Unknown opcode 0xFE → bundle with `ins_unknown=1`, len0, fetch continues at the next byte.
- Reset asserted in CAP_OPND1 of a sipush → next cycle IDLE, all outputs at reset values; a subsequent `start` refetches from the new start_pc.
